// File: rtl/sprite_line_renderer.sv
// Double-buffered sprite line renderer.
// During horizontal blanking the entity list is snapshotted and scanned, and the sprite row for
// the next display line is fetched from the sprite ROM into the back line buffer, one entry per
// tile column. During active video the front buffer is streamed out as a 1-bit pixel. The
// buffers swap at the last pixel of every line.
// Ports:
//   clk, reset            pixel clock, asynchronous active-low reset
//   entities              NUM_ENTITIES x {id[3:0], orient[1:0], loc[7:0]} (id 4'hF = unused)
//   counter_H, counter_V  current pixel column / line from the VGA timing counters
//   rom_req .. rom_line   ROM request and its sprite id / orientation / sprite row
//   rom_ack, rom_data     ROM completion and row bitmap (bit 0 = leftmost)
//   colour                registered pixel output (one clock behind the counters)
//   overrun               sticky flag: a fetch was still running at the swap point
module sprite_line_renderer #(
  parameter int unsigned NUM_ENTITIES = 8,
  parameter int unsigned TILES_H      = 16,
  parameter int unsigned TILES_V      = 12,
  parameter int unsigned SPRITE_PX    = 8,
  parameter int unsigned UPSCALE      = 5,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_TOTAL      = 525,
  parameter bit          BG_COLOUR    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [14*NUM_ENTITIES-1:0]  entities,
  input  logic [9:0]                  counter_H,
  input  logic [9:0]                  counter_V,
  output logic                        rom_req,
  output logic [3:0]                  rom_sprite_id,
  output logic [1:0]                  rom_orient,
  output logic [2:0]                  rom_line,
  input  logic                        rom_ack,
  input  logic [SPRITE_PX-1:0]        rom_data,
  output logic                        colour,
  output logic                        overrun
);

  localparam int unsigned TILE_PX = SPRITE_PX * UPSCALE;
  localparam int unsigned COL_W   = (TILES_H > 1) ? $clog2(TILES_H) : 1;
  localparam int unsigned IDX_W   = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;

  typedef enum logic [2:0] {StIdle, StClear, StScan, StReq, StDone} state_e;

  // Quotient by the tile size using constant compares only.
  function automatic logic [4:0] tile_quot(input logic [9:0] v);
    logic [4:0] q;
    q = '0;
    for (int k = 1; k < 32; k++) begin
      if (32'(v) >= k * TILE_PX) q = 5'(k);
    end
    return q;
  endfunction

  // Quotient of an in-tile offset by the upscale factor.
  function automatic logic [2:0] px_quot(input logic [9:0] rem);
    logic [2:0] q;
    q = '0;
    for (int k = 1; k < SPRITE_PX && k < 8; k++) begin
      if (32'(rem) >= k * UPSCALE) q = 3'(k);
    end
    return q;
  endfunction

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [4:0]             row_q;
  logic [2:0]             sr_q;
  logic                   blank_q;
  logic                   front_q;
  logic [13:0]            ent_q  [NUM_ENTITIES];
  logic [SPRITE_PX-1:0]   line_q [2][TILES_H];
  logic [TILES_H-1:0]     valid_q [2];

  logic [9:0]  t_line;
  logic [4:0]  t_row;
  logic [2:0]  t_sr;
  logic        t_blank;
  logic [4:0]  d_col;
  logic [2:0]  d_px;
  logic        d_vis;
  logic        back;
  logic [13:0] cur;
  logic [COL_W-1:0] cur_col;
  logic        qualifies;
  logic        last;

  always_comb begin
    t_line  = (counter_V == 10'(V_TOTAL - 1)) ? 10'd0 : counter_V + 10'd1;
    t_row   = tile_quot(t_line);
    t_sr    = px_quot(t_line - 10'(t_row * TILE_PX));
    t_blank = (32'(t_line) >= V_VISIBLE);
    d_col   = tile_quot(counter_H);
    d_px    = px_quot(counter_H - 10'(d_col * TILE_PX));
    d_vis   = (32'(counter_H) < H_VISIBLE) && (32'(counter_V) < V_VISIBLE);
    back    = ~front_q;
    cur     = ent_q[idx_q];
    cur_col = COL_W'(cur[3:0]);
    // Skip columns already filled this line so the lowest channel index wins a shared tile.
    qualifies = (cur[13:10] != 4'hF) && ({1'b0, cur[7:4]} == row_q) &&
                (32'(cur[7:4]) < TILES_V) && (32'(cur[3:0]) < TILES_H) &&
                !valid_q[back][cur_col];
    last    = (idx_q == IDX_W'(NUM_ENTITIES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      row_q         <= '0;
      sr_q          <= '0;
      blank_q       <= 1'b0;
      front_q       <= 1'b0;
      rom_req       <= 1'b0;
      rom_sprite_id <= '0;
      rom_orient    <= '0;
      rom_line      <= '0;
      overrun       <= 1'b0;
      valid_q[0]    <= '0;
      valid_q[1]    <= '0;
      for (int i = 0; i < NUM_ENTITIES; i++) ent_q[i] <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < TILES_H; c++) line_q[b][c] <= '0;
      end
    end else if (counter_H == 10'(H_TOTAL - 1)) begin
      // Swap point wins over everything; an unfinished fetch is abandoned.
      front_q <= ~front_q;
      if (state_q != StIdle && state_q != StDone) overrun <= 1'b1;
      state_q <= StIdle;
      rom_req <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (counter_H == 10'(H_VISIBLE)) begin
            for (int i = 0; i < NUM_ENTITIES; i++) ent_q[i] <= entities[14*i +: 14];
            row_q   <= t_row;
            sr_q    <= t_sr;
            blank_q <= t_blank;
            state_q <= StClear;
          end
        end
        StClear: begin
          valid_q[back] <= '0;
          idx_q         <= '0;
          state_q       <= blank_q ? StDone : StScan;
        end
        StScan: begin
          if (qualifies) begin
            rom_req       <= 1'b1;
            rom_sprite_id <= cur[13:10];
            rom_orient    <= cur[9:8];
            rom_line      <= sr_q;
            state_q       <= StReq;
          end else if (last) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StReq: begin
          if (rom_ack) begin
            line_q[back][cur_col]  <= rom_data;
            valid_q[back][cur_col] <= 1'b1;
            rom_req                <= 1'b0;
            if (last) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StScan;
            end
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colour <= 1'b0;
    end else if (d_vis) begin
      colour <= (32'(d_col) < TILES_H && valid_q[front_q][COL_W'(d_col)]) ?
                line_q[front_q][COL_W'(d_col)][d_px] : BG_COLOUR;
    end else begin
      colour <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: fetches lines through a small ROM model and checks
// ROM traffic, overrun behaviour, reset and the rendered pixels at hand-picked columns.
module tb_sprite_line_renderer;

  logic         clk;
  logic         reset;
  logic [111:0] entities;
  logic [9:0]   counter_H;
  logic [9:0]   counter_V;
  logic         rom_req;
  logic [3:0]   rom_sprite_id;
  logic [1:0]   rom_orient;
  logic [2:0]   rom_line;
  logic         rom_ack;
  logic [7:0]   rom_data;
  logic         colour;
  logic         overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] rom_table [16];
  logic       ack_en;
  int         n_req;
  logic       saw_req;
  logic [3:0] last_id;
  logic [1:0] last_orient;
  logic [2:0] last_line;

  sprite_line_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .entities      (entities),
    .counter_H     (counter_H),
    .counter_V     (counter_V),
    .rom_req       (rom_req),
    .rom_sprite_id (rom_sprite_id),
    .rom_orient    (rom_orient),
    .rom_line      (rom_line),
    .rom_ack       (rom_ack),
    .rom_data      (rom_data),
    .colour        (colour),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given counters; ROM answers in the cycle after rom_req is seen.
  task automatic step(input int h, input int v);
    @(negedge clk);
    counter_H = 10'(h);
    counter_V = 10'(v);
    rom_ack   = ack_en && rom_req;
    rom_data  = rom_table[rom_sprite_id];
    if (rom_ack) begin
      n_req++;
      last_id     = rom_sprite_id;
      last_orient = rom_orient;
      last_line   = rom_line;
    end
    @(posedge clk);
    #1;
    if (rom_req) saw_req = 1'b1;
  endtask

  task automatic fetch_line(input int v);
    n_req   = 0;
    saw_req = 1'b0;
    for (int h = 640; h < 800; h++) step(h, v);
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic exp);
    step(h, v);
    check(tag, 32'(colour), 32'(exp));
  endtask

  task automatic clear_entities();
    entities = '1;
  endtask

  task automatic set_ent(input int i, input logic [3:0] id, input logic [1:0] ori,
                         input logic [7:0] loc);
    entities[14*i +: 14] = {id, ori, loc};
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_table[i] = 8'h00;
    rom_table[3] = 8'b0000_0101;
    rom_table[4] = 8'hFF;
    rom_table[6] = 8'h01;
    rom_table[7] = 8'hF0;
    rom_table[9] = 8'h0F;
    ack_en    = 1'b1;
    rom_ack   = 1'b0;
    rom_data  = '0;
    counter_H = '0;
    counter_V = '0;
    n_req     = 0;
    saw_req   = 1'b0;
    last_id   = '0;
    last_orient = '0;
    last_line = '0;
    clear_entities();
    reset = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rom_req", 32'(rom_req), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sprite_id", 32'(rom_sprite_id), 32'd0);
    reset = 1'b1;

    // Single sprite at row 2 / column 2, fetched for line 80
    set_ent(0, 4'd3, 2'b10, 8'h22);
    fetch_line(79);
    check("t1_req_count", 32'(n_req), 32'd1);
    check("t1_id", 32'(last_id), 32'd3);
    check("t1_orient", 32'(last_orient), 32'd2);
    check("t1_line", 32'(last_line), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);
    pix("t1_h0", 0, 80, 1'b1);
    pix("t1_h79", 79, 80, 1'b1);
    pix("t1_h80", 80, 80, 1'b1);
    pix("t1_h84", 84, 80, 1'b1);
    pix("t1_h85", 85, 80, 1'b0);
    pix("t1_h89", 89, 80, 1'b0);
    pix("t1_h90", 90, 80, 1'b1);
    pix("t1_h94", 94, 80, 1'b1);
    pix("t1_h95", 95, 80, 1'b0);
    pix("t1_h119", 119, 80, 1'b0);
    pix("t1_h120", 120, 80, 1'b1);
    pix("t1_h639", 639, 80, 1'b1);
    pix("t1_hblank", 700, 80, 1'b0);

    // Two entities on the same tile: lower channel wins, one request
    clear_entities();
    set_ent(2, 4'd7, 2'b01, 8'h00);
    set_ent(5, 4'd9, 2'b00, 8'h00);
    fetch_line(9);
    check("t2_req_count", 32'(n_req), 32'd1);
    check("t2_id", 32'(last_id), 32'd7);
    check("t2_line", 32'(last_line), 32'd2);
    pix("t2_h0", 0, 10, 1'b0);
    pix("t2_h20", 20, 10, 1'b1);
    pix("t2_h40", 40, 10, 1'b1);

    // Frame wrap: line 524 fetches line 0; the row-12 entity is never requested
    clear_entities();
    set_ent(0, 4'd4, 2'b00, 8'hC3);
    set_ent(1, 4'd6, 2'b00, 8'h05);
    fetch_line(524);
    check("t5_req_count", 32'(n_req), 32'd1);
    check("t5_id", 32'(last_id), 32'd6);
    check("t5_line", 32'(last_line), 32'd0);
    pix("t5_h200", 200, 0, 1'b1);
    pix("t5_h205", 205, 0, 1'b0);
    pix("t5_h120", 120, 0, 1'b1);

    // No active entities: background everywhere visible, black in blanking
    clear_entities();
    fetch_line(200);
    check("t3_req_count", 32'(n_req), 32'd0);
    check("t3_saw_req", 32'(saw_req), 32'd0);
    pix("t3_h0", 0, 201, 1'b1);
    pix("t3_h300", 300, 201, 1'b1);
    pix("t3_h639", 639, 201, 1'b1);
    pix("t3_hblank", 700, 201, 1'b0);
    pix("t3_vblank", 100, 490, 1'b0);

    // Withheld ack: overrun at the swap point, request dropped, background shown
    set_ent(0, 4'd3, 2'b00, 8'h22);
    ack_en = 1'b0;
    fetch_line(79);
    check("t4_saw_req", 32'(saw_req), 32'd1);
    check("t4_req_count", 32'(n_req), 32'd0);
    check("t4_rom_req", 32'(rom_req), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd1);
    pix("t4_h80", 80, 80, 1'b1);
    ack_en = 1'b1;
    clear_entities();
    fetch_line(200);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Reset asserted mid-request
    set_ent(0, 4'd3, 2'b00, 8'h22);
    ack_en = 1'b0;
    for (int h = 640; h <= 650; h++) step(h, 79);
    step(100, 300);
    check("t6_pre_rom_req", 32'(rom_req), 32'd1);
    check("t6_pre_colour", 32'(colour), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rom_req", 32'(rom_req), 32'd0);
    check("t6_colour", 32'(colour), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ack_en = 1'b1;
    fetch_line(79);
    check("t6_req_count", 32'(n_req), 32'd1);
    check("t6_overrun_after", 32'(overrun), 32'd0);
    pix("t6_h85", 85, 80, 1'b0);
    pix("t6_h90", 90, 80, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
